// File: rtl/fir_pkg.sv
// Shared definitions for the FIR decimator.
// IN_W / ACC_W fix the input sample and accumulator widths; SUM_W leaves one
// bit of headroom for the rounding add.
// sat_max / sat_min give the signed clamp limits for an OUT_W-bit result,
// expressed in the SUM_W domain so they can be compared directly.
package fir_pkg;
   localparam int IN_W  = 8;
   localparam int ACC_W = 12;
   localparam int SUM_W = ACC_W + 1;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [SUM_W-1:0] sum_t;

   function automatic sum_t sat_max(input int out_w);
      return sum_t'((1 <<< (out_w - 1)) - 1);
   endfunction

   function automatic sum_t sat_min(input int out_w);
      return sum_t'(-(1 <<< (out_w - 1)));
   endfunction
endpackage

// File: rtl/fir_out_fifo.sv
// Two-entry FIFO that holds decimated output samples.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   push_i, data_i   write one entry (ignored when full)
//   pop_i            read request; acts only when an entry is present
//   data_o           head entry (entry storage resets to zero)
//   valid_o          FIFO non-empty
//   full_o           both entries occupied (registered, no path from pop_i)
module fir_out_fifo #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic         full_o
);
   logic [W-1:0] mem_q [2];
   logic         wr_q, rd_q;
   logic [1:0]   cnt_q, cnt_d;
   logic         push, pop;

   assign valid_o = (cnt_q != 2'd0);
   assign full_o  = (cnt_q == 2'd2);
   assign data_o  = mem_q[rd_q];
   assign pop     = pop_i & valid_o;
   assign push    = push_i & ~full_o;

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/fir_decim.sv
// Decimating accumulator for an FIR output stream.
// Sums DECIM signed input samples, rounds half-up, divides by DECIM, clamps
// to OUT_W bits and queues the result in a 2-entry output FIFO.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready  input sample stream
//   sync_clr                    synchronous clear of accumulator and phase
//   m_axis_tdata/tvalid/tready  decimated output stream (FIFO head)
//   ovf                         sticky saturation flag
module fir_decim
   import fir_pkg::*;
#(
   parameter int DECIM = 4,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             sync_clr,
   output logic [OUT_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             ovf
);
   localparam int              SHIFT   = $clog2(DECIM);
   localparam int              PH_W    = SHIFT;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
   localparam sum_t            RND     = sum_t'(1 <<< (SHIFT - 1));
   localparam sum_t            LIM_HI  = sat_max(OUT_W);
   localparam sum_t            LIM_LO  = sat_min(OUT_W);

   acc_t             acc_q, acc_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic             ovf_q;
   logic             rdy_en_q;
   logic             fifo_full;
   logic             accept, last, push;
   sum_t             sum, rounded, shifted;
   logic             sat_hi, sat_lo;
   logic [OUT_W-1:0] res;

   // rdy_en_q holds ready low until the first edge after reset releases.
   // Ready depends only on registered FIFO state, never on m_axis_tready.
   assign s_axis_tready = rdy_en_q & ~fifo_full & ~sync_clr;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign last          = (phase_q == PH_LAST);
   assign push          = accept & last;
   assign ovf           = ovf_q;

   always_comb begin
      sum     = {acc_q[ACC_W-1], acc_q}
              + {{(SUM_W-IN_W){s_axis_tdata[IN_W-1]}}, s_axis_tdata};
      rounded = sum + RND;
      shifted = rounded >>> SHIFT;
      sat_hi  = (shifted > LIM_HI);
      sat_lo  = (shifted < LIM_LO);
      if (sat_hi)      res = LIM_HI[OUT_W-1:0];
      else if (sat_lo) res = LIM_LO[OUT_W-1:0];
      else             res = shifted[OUT_W-1:0];
   end

   always_comb begin
      acc_d   = acc_q;
      phase_d = phase_q;
      if (sync_clr) begin
         acc_d   = '0;
         phase_d = '0;
      end else if (accept) begin
         if (last) begin
            acc_d   = '0;
            phase_d = '0;
         end else begin
            acc_d   = sum[ACC_W-1:0];
            phase_d = phase_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q    <= '0;
         phase_q  <= '0;
         ovf_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         phase_q  <= phase_d;
         ovf_q    <= ovf_q | (push & (sat_hi | sat_lo));
         rdy_en_q <= 1'b1;
      end
   end

   fir_out_fifo #(.W(OUT_W)) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (push),
      .data_i  (res),
      .pop_i   (m_axis_tready),
      .data_o  (m_axis_tdata),
      .valid_o (m_axis_tvalid),
      .full_o  (fifo_full)
   );
endmodule

// File: tb/tb_fir_decim.sv
// Bench for fir_decim: two instances (OUT_W=8 and OUT_W=6) share all inputs.
// Expected outputs come from an integer model and are queued on each accept,
// then popped by a monitor whenever the DUT hands a sample downstream.
module tb_fir_decim;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] s_tdata = '0;
   logic       s_tvalid = 1'b0;
   logic       sync_clr = 1'b0;
   logic       m_tready = 1'b0;
   logic       s_tready, m_tvalid, ovf;
   logic [7:0] m_tdata;
   logic       s_tready6, m_tvalid6, ovf6;
   logic [5:0] m_tdata6;

   always #5 clk = ~clk;

   fir_decim #(.DECIM(4), .OUT_W(8)) dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .sync_clr(sync_clr),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .ovf(ovf)
   );

   fir_decim #(.DECIM(4), .OUT_W(6)) dut6 (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready6),
      .sync_clr(sync_clr),
      .m_axis_tdata(m_tdata6), .m_axis_tvalid(m_tvalid6), .m_axis_tready(m_tready),
      .ovf(ovf6)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int d8; int d6; } exp_t;
   exp_t sb[$];
   int   m_sum = 0;
   int   m_cnt = 0;
   int   last_acc_cyc = 0;

   function automatic int clamp(input int v, input int w);
      int hi, lo;
      hi = (1 <<< (w - 1)) - 1;
      lo = -(1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic void model_accept(input int d);
      exp_t e;
      int   r;
      m_sum += d;
      m_cnt++;
      if (m_cnt == 4) begin
         r    = (m_sum + 2) >>> 2;
         e.d8 = clamp(r, 8);
         e.d6 = clamp(r, 6);
         sb.push_back(e);
         m_sum = 0;
         m_cnt = 0;
      end
   endfunction

   // Scoreboard monitor: a transfer happens on the next edge.
   exp_t mon_e;
   int   got8, got6;
   always @(negedge clk) begin
      if (reset && m_tvalid && m_tready) begin
         got8 = int'($signed(m_tdata));
         got6 = int'($signed(m_tdata6));
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected got=%0d want=none", got8);
         end else begin
            mon_e = sb.pop_front();
            if (got8 !== mon_e.d8) begin
               failures++;
               $display("FAIL out8 got=%0d want=%0d", got8, mon_e.d8);
            end
            checks++;
            if (!m_tvalid6 || got6 !== mon_e.d6) begin
               failures++;
               $display("FAIL out6 got=%0d valid=%0b want=%0d", got6, m_tvalid6, mon_e.d6);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one sample and hold it until accepted; leaves tvalid high.
   task automatic send(input int d);
      bit ok;
      ok = 1'b0;
      s_tdata  = 8'(d);
      s_tvalid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (s_tready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout data=%0d tready=%0b want=1", d, s_tready);
         s_tvalid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      model_accept(d);
      last_acc_cyc = cyc;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cycles(2);
      checks++;
      if (m_tvalid !== 1'b0 || m_tdata !== 8'd0 || s_tready !== 1'b0 || ovf !== 1'b0 || ovf6 !== 1'b0) begin
         failures++;
         $display("FAIL reset_outs got v=%0b d=%0d r=%0b o=%0b o6=%0b want all 0",
                  m_tvalid, m_tdata, s_tready, ovf, ovf6);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (s_tready !== 1'b0) begin
         failures++;
         $display("FAIL ready_before_edge got=%0b want=0", s_tready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (s_tready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_edge got=%0b want=1", s_tready);
      end
      m_tready = 1'b1;
   endtask

   task automatic test_basic();
      send(10); send(20); send(30);
      checks++;
      if (m_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL latency_early got=%0b want=0", m_tvalid);
      end
      send(40);
      s_tvalid = 1'b0;
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'd25) begin
         failures++;
         $display("FAIL basic_out got v=%0b d=%0d want v=1 d=25", m_tvalid, m_tdata);
      end
      cycles(3);
      checks++;
      if (ovf !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL basic_end got ovf=%0b pending=%0d want 0 0", ovf, sb.size());
      end
   endtask

   task automatic test_saturation();
      checks++;
      if (ovf6 !== 1'b0) begin
         failures++;
         $display("FAIL ovf6_pre got=%0b want=0", ovf6);
      end
      repeat (4) send(100);
      s_tvalid = 1'b0;
      checks++;
      if (m_tdata6 !== 6'd31 || ovf6 !== 1'b1 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL sat_out got d6=%0d o6=%0b o8=%0b want 31 1 0", m_tdata6, ovf6, ovf);
      end
      repeat (4) send(0);
      s_tvalid = 1'b0;
      cycles(3);
      checks++;
      if (ovf6 !== 1'b1 || sb.size() != 0) begin
         failures++;
         $display("FAIL ovf6_sticky got=%0b pending=%0d want 1 0", ovf6, sb.size());
      end
   endtask

   task automatic test_rounding();
      send(-3); send(-3); send(-3); send(-2);
      checks++;
      if ($signed(m_tdata) !== -8'sd3) begin
         failures++;
         $display("FAIL round_neg got=%0d want=-3", $signed(m_tdata));
      end
      repeat (4) send(127);
      checks++;
      if (m_tdata !== 8'd127) begin
         failures++;
         $display("FAIL pos_full got=%0d want=127", m_tdata);
      end
      repeat (4) send(-128);
      s_tvalid = 1'b0;
      checks++;
      if (m_tdata !== 8'h80) begin
         failures++;
         $display("FAIL neg_full got=%0d want=-128", $signed(m_tdata));
      end
      cycles(3);
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf8_clean got=%0b want=0", ovf);
      end
   endtask

   task automatic test_back_to_back();
      int pop_cyc;
      m_tready = 1'b0;
      for (int i = 0; i < 8; i++) send(i * 7 - 40);
      checks++;
      if (s_tready !== 1'b0 || m_tvalid !== 1'b1) begin
         failures++;
         $display("FAIL full_stall got r=%0b v=%0b want 0 1", s_tready, m_tvalid);
      end
      s_tdata  = 8'(8 * 7 - 40);
      s_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycles(1);
         checks++;
         if (s_tready !== 1'b0 || int'($signed(m_tdata)) !== sb[0].d8) begin
            failures++;
            $display("FAIL hold got r=%0b d=%0d want 0 %0d", s_tready, $signed(m_tdata), sb[0].d8);
         end
      end
      m_tready = 1'b1;
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0) begin
         failures++;
         $display("FAIL ready_during_pop got=%0b want=0", s_tready);
      end
      @(posedge clk);
      #1;
      pop_cyc = cyc;
      send(8 * 7 - 40);
      checks++;
      if (last_acc_cyc != pop_cyc + 1) begin
         failures++;
         $display("FAIL resume_cycle got=%0d want=%0d", last_acc_cyc, pop_cyc + 1);
      end
      for (int i = 9; i < 12; i++) send(i * 7 - 40);
      s_tvalid = 1'b0;
      cycles(6);
      checks++;
      if (sb.size() != 0 || m_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL drain got pending=%0d v=%0b want 0 0", sb.size(), m_tvalid);
      end
   endtask

   task automatic test_sync_clr();
      m_tready = 1'b1;
      send(50); send(60);
      s_tvalid = 1'b0;
      sync_clr = 1'b1;
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0) begin
         failures++;
         $display("FAIL ready_in_clr got=%0b want=0", s_tready);
      end
      @(posedge clk);
      #1;
      sync_clr = 1'b0;
      m_sum = 0;
      m_cnt = 0;
      send(4); send(8); send(12); send(16);
      s_tvalid = 1'b0;
      checks++;
      if (m_tdata !== 8'd10) begin
         failures++;
         $display("FAIL clr_out got=%0d want=10", $signed(m_tdata));
      end
      cycles(3);
   endtask

   task automatic test_reset_mid();
      m_tready = 1'b0;
      send(1); send(2); send(3); send(4);
      send(5); send(6);
      s_tvalid = 1'b0;
      cycles(1);
      checks++;
      if (m_tvalid !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_entry got=%0b want=1", m_tvalid);
      end
      #2 reset = 1'b0;
      #1;
      sb.delete();
      m_sum = 0;
      m_cnt = 0;
      checks++;
      if (m_tvalid !== 1'b0 || m_tdata !== 8'd0 || s_tready !== 1'b0 || ovf6 !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got v=%0b d=%0d r=%0b o6=%0b want 0 0 0 0",
                  m_tvalid, m_tdata, s_tready, ovf6);
      end
      cycles(1);
      reset = 1'b1;
      cycles(1);
      checks++;
      if (s_tready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset got=%0b want=1", s_tready);
      end
      m_tready = 1'b1;
      send(20); send(20); send(20); send(21);
      s_tvalid = 1'b0;
      checks++;
      if (m_tdata !== 8'd20) begin
         failures++;
         $display("FAIL fresh_out got=%0d want=20", $signed(m_tdata));
      end
      cycles(3);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_back_to_back();
      test_sync_clr();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL outputs_missing got=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running want=finished");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fir_decim.md
FIR_DECIM -- requirements
Module: fir_decim

Interface
REQ-001 Parameter DECIM, default 4, decimation factor; SHALL be a power of two in 2..16.
REQ-002 Parameter OUT_W, default 8, output sample width in bits; SHALL be in 4..8.
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 s_axis_tdata  input  8  signed FIR output sample, two's complement.
REQ-006 s_axis_tvalid  input  1  upstream sample valid.
REQ-007 s_axis_tready  output  1  this block can accept a sample.
REQ-008 sync_clr  input  1  synchronous clear of the accumulator and phase counter.
REQ-009 m_axis_tdata  output  OUT_W  signed decimated sample, driven from the FIFO head.
REQ-010 m_axis_tvalid  output  1  FIFO is non-empty.
REQ-011 m_axis_tready  input  1  downstream accepts the head sample.
REQ-012 ovf  output  1  sticky flag, set when any output saturates.

Function
REQ-013 Accept rule: a sample SHALL be accepted on an edge where s_axis_tvalid=1, s_axis_tready=1 and sync_clr=0.
REQ-014 s_axis_tready SHALL equal NOT(FIFO full) AND NOT sync_clr; it SHALL have no combinational path from m_axis_tready.
REQ-015 Accumulator: 12-bit signed; sign-extended samples SHALL be summed; the phase counter SHALL count accepted samples 0..DECIM-1.
REQ-016 On acceptance at phase DECIM-1, the block SHALL push result = (acc + sample + 2^(SHIFT-1)) >>> SHIFT into the FIFO, where SHIFT = log2(DECIM); it SHALL clear acc and reset phase to 0 on the same edge.
REQ-017 Saturation: the result SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; ovf SHALL set on the push edge when clamping occurs; ovf SHALL clear only on reset.
REQ-018 Latency: m_axis_tvalid SHALL rise one cycle after the edge that accepts the DECIM-th sample; there SHALL be no bypass path.
REQ-019 Output FIFO: 2 entries, first in first out; a pop SHALL occur on an edge with m_axis_tvalid=1 and m_axis_tready=1.
REQ-020 Push and pop on the same edge SHALL keep the occupancy unchanged and preserve order.
REQ-021 When the FIFO is full and popped, s_axis_tready SHALL stay 0 that cycle and rise on the next cycle.
REQ-022 Because of REQ-014, a push SHALL never occur while the FIFO is full; no sample is dropped.
REQ-023 sync_clr=1 SHALL zero acc and phase on that edge and SHALL force s_axis_tready=0; it SHALL leave the FIFO and ovf unaffected.
REQ-024 m_axis_tdata SHALL hold a stable value while m_axis_tvalid=1 and m_axis_tready=0.

Reset
REQ-025 reset=0 SHALL asynchronously clear acc, phase, FIFO pointers and occupancy, and ovf.
REQ-026 Reset SHALL produce m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, ovf=0.
REQ-027 s_axis_tready SHALL rise on the first edge after reset deasserts.
REQ-028 Reset mid-accumulation SHALL discard the partial sum and all FIFO contents.

Structure
REQ-029 Sample widths (IN_W=8, ACC_W=12) and the saturation limit function SHALL live in the shared package fir_pkg.
REQ-030 The 2-entry FIFO SHALL be a sub-module fir_out_fifo, parameterised on width.
REQ-031 Accumulation, rounding and saturation SHALL stay in fir_decim.

Verification
REQ-032 DECIM=4, OUT_W=8; inputs 10, 20, 30, 40 back-to-back, m_axis_tready=1 -> single output 25, one cycle after the 4th accept; ovf=0.
REQ-033 Inputs -3, -3, -3, -2 -> output -3 (sum -11, rounded half-up); inputs 127 x4 -> 127; inputs -128 x4 -> -128.
REQ-034 OUT_W=6; inputs 100 x4 -> output 31 and ovf=1; a following input set 0 x4 -> output 0, ovf stays 1.
REQ-035 m_axis_tready=0, stream 12 samples -> s_axis_tready=0 after the 8th accept with 2 outputs held; raise m_axis_tready -> outputs drain in order, 9th sample accepted one cycle after the first pop, no loss.
REQ-036 sync_clr asserted after 2 accepted samples -> next 4 samples alone form the output.
REQ-037 reset asserted mid-accumulation with 1 FIFO entry -> m_axis_tvalid=0 immediately; next 4 samples produce a correct fresh output.
